// File: rtl/cla_4bit_augmented.sv
// 4-bit carry-lookahead adder with block propagate/generate outputs.
// This is the leaf arithmetic cell of the KGPminiRISC ALU.
// All carries come from a flat sum-of-products network, so no carry ripples.
// P and G are brought out so that a second-level lookahead unit can cascade blocks.
// Results are registered with a latency of one cycle.
module cla_4bit_augmented (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out,
   output logic       prop,
   output logic       gen,
   output logic       out_valid
);

   localparam int unsigned W = 4;

   logic [W-1:0] g_c;
   logic [W-1:0] p_c;
   logic [W-1:0] c_c;
   logic [W-1:0] sum_c;
   logic         blk_p_c;
   logic         blk_g_c;
   logic         c_out_c;

   // Flat lookahead core: each carry is a sum of products of bit terms and c_in.
   always_comb begin
      g_c   = a & b;
      p_c   = a ^ b;
      c_c   = '0;

      c_c[0] = c_in;
      c_c[1] = g_c[0]
             | (p_c[0] & c_in);
      c_c[2] = g_c[1]
             | (p_c[1] & g_c[0])
             | (p_c[1] & p_c[0] & c_in);
      c_c[3] = g_c[2]
             | (p_c[2] & g_c[1])
             | (p_c[2] & p_c[1] & g_c[0])
             | (p_c[2] & p_c[1] & p_c[0] & c_in);

      sum_c = p_c ^ c_c;

      // Block terms are independent of c_in, so an upper lookahead level can use them.
      blk_p_c = &p_c;
      blk_g_c = g_c[3]
              | (p_c[3] & g_c[2])
              | (p_c[3] & p_c[2] & g_c[1])
              | (p_c[3] & p_c[2] & p_c[1] & g_c[0]);

      c_out_c = blk_g_c | (blk_p_c & c_in);
   end

   // Result register: load on in_valid, otherwise hold. Reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         c_out     <= 1'b0;
         prop      <= 1'b0;
         gen       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum   <= sum_c;
            c_out <= c_out_c;
            prop  <= blk_p_c;
            gen   <= blk_g_c;
         end
      end
   end

endmodule

// File: tb/tb_cla_4bit_augmented.sv
// Self-checking bench for cla_4bit_augmented: directed table, hold/reset sequences,
// exhaustive sweep, with a scoreboard queue of expected results.
module tb_cla_4bit_augmented;

   typedef struct packed {
      logic [3:0] sum;
      logic       cout;
      logic       prop;
      logic       gen;
   } res_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      res_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       c_in;
   logic [3:0] sum;
   logic       c_out;
   logic       prop;
   logic       gen;
   logic       out_valid;

   int   n_tests = 0;
   int   n_fail  = 0;
   res_t sb[$];
   res_t held;

   cla_4bit_augmented dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sum       (sum),
      .c_out     (c_out),
      .prop      (prop),
      .gen       (gen),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Reference: plain integer add; G is "a+b alone carries out", P is "all bits propagate".
   function automatic res_t model(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
      res_t       r;
      logic [4:0] t;
      logic [4:0] ab;
      t      = 5'(xa) + 5'(xb) + 5'(xc);
      ab     = 5'(xa) + 5'(xb);
      r.sum  = t[3:0];
      r.cout = t[4];
      r.prop = &(xa ^ xb);
      r.gen  = ab[4];
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got {v,cout,sum,P,G}=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                  name, got[7], got[6], got[5:2], got[1], got[0],
                  exp[7], exp[6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   // Drive one cycle; push the expected result if a capture is due, then check after the edge.
   task automatic cycle(input logic r, input logic v, input logic [3:0] xa, input logic [3:0] xb,
                        input logic xc, input res_t e, input string name);
      res_t exp_r;
      logic exp_v;
      rst      = r;
      in_valid = v;
      a        = xa;
      b        = xb;
      c_in     = xc;
      if (r) begin
         sb.delete();
         held = '0;
      end else if (v) begin
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         exp_r = sb.pop_front();
         held  = exp_r;
         exp_v = 1'b1;
      end else begin
         exp_r = held;
         exp_v = 1'b0;
      end
      check(name, {out_valid, c_out, sum, prop, gen},
            {exp_v, exp_r.cout, exp_r.sum, exp_r.prop, exp_r.gen});
   endtask

   vec_t tbl[5];

   initial begin
      res_t       e;
      logic [8:0] idx;

      tbl[0] = '{4'b0100, 4'b1001, 1'b0, '{4'b1101, 1'b0, 1'b0, 1'b0}};
      tbl[1] = '{4'b1001, 4'b1010, 1'b0, '{4'b0011, 1'b1, 1'b0, 1'b1}};
      tbl[2] = '{4'b1100, 4'b0011, 1'b0, '{4'b1111, 1'b0, 1'b1, 1'b0}};
      tbl[3] = '{4'b1100, 4'b0011, 1'b1, '{4'b0000, 1'b1, 1'b1, 1'b0}};
      tbl[4] = '{4'b1111, 4'b1111, 1'b0, '{4'b1110, 1'b1, 1'b0, 1'b1}};

      held = '0;
      e    = '0;

      // Reset for two cycles with in_valid asserted and live inputs.
      cycle(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, e, "reset_cycle0");
      cycle(1'b1, 1'b1, 4'h7, 4'h9, 1'b1, e, "reset_cycle1");
      cycle(1'b0, 1'b0, 4'h3, 4'h5, 1'b0, e, "post_reset_idle");

      // Directed vectors back-to-back.
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp, $sformatf("table_%0d", i));

      // Drop in_valid: result holds and out_valid falls, whatever the inputs are doing.
      cycle(1'b0, 1'b0, 4'h1, 4'h2, 1'b1, e, "hold_0");
      cycle(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, e, "hold_1");

      // Exhaustive sweep of all 512 operand triples, back-to-back.
      for (int i = 0; i < 512; i++) begin
         idx = 9'(i);
         e   = model(idx[3:0], idx[7:4], idx[8]);
         cycle(1'b0, 1'b1, idx[3:0], idx[7:4], idx[8], e, $sformatf("sweep_%0d", i));
      end
      cycle(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, e, "sweep_hold");

      // Reset with a capture pending discards that capture.
      e = model(4'h6, 4'h7, 1'b1);
      cycle(1'b0, 1'b1, 4'h6, 4'h7, 1'b1, e, "pre_midreset");
      cycle(1'b1, 1'b1, 4'hA, 4'h5, 1'b1, e, "midreset");
      cycle(1'b0, 1'b0, 4'hA, 4'h5, 1'b1, e, "midreset_after");

      // Single pulse with an idle cycle around it.
      e = model(4'h8, 4'h8, 1'b1);
      cycle(1'b0, 1'b1, 4'h8, 4'h8, 1'b1, e, "pulse");
      cycle(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, e, "pulse_hold");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
